// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the TDM demultiplexer slice.
//   tdm_state_t : frame FSM state (IDLE waiting for a frame start, RUN inside
//                 a frame).
//   TDM_N_CH    : default number of channels (slots per frame).
//   TDM_W       : default data width per beat/channel.
//   slot_w()    : width of the slot counter for a given channel count.
// -----------------------------------------------------------------------------
package tdm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } tdm_state_t;

   localparam int TDM_N_CH = 4;
   localparam int TDM_W    = 8;

   // Number of bits needed to index n slots (n >= 2, so never zero).
   function automatic int slot_w(input int n);
      return $clog2(n);
   endfunction

endpackage : tdm_pkg

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Modulo-N_CH slot counter for the TDM demultiplexer.
// Ports:
//   clk_i         : rising-edge clock
//   rst_ni        : asynchronous active-low reset (slot returns to 0)
//   inc_i         : advance one slot; wraps from N_CH-1 back to 0
//   clr_to_one_i  : load 1 (slot 0 was just taken by a frame-start beat);
//                   has priority over inc_i
//   slot_o        : current slot index (never reaches N_CH)
//   last_o        : high while slot_o == N_CH-1
// -----------------------------------------------------------------------------
module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter int N_CH   = TDM_N_CH,
   parameter int SLOT_W = slot_w(TDM_N_CH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              inc_i,
   input  logic              clr_to_one_i,
   output logic [SLOT_W-1:0] slot_o,
   output logic              last_o
);

   localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_CH - 1);

   logic [SLOT_W-1:0] slot_q;
   logic [SLOT_W-1:0] slot_d;
   logic              last_s;

   // Terminal flag and next slot value.
   always_comb begin
      slot_d = slot_q;
      last_s = (slot_q == SLOT_LAST);
      if (clr_to_one_i) begin
         slot_d = SLOT_ONE;
      end else if (inc_i) begin
         // Explicit wrap: N_CH need not be a power of two.
         if (last_s) begin
            slot_d = SLOT_ZERO;
         end else begin
            slot_d = slot_q + SLOT_ONE;
         end
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= SLOT_ZERO;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot_o = slot_q;
   assign last_o = last_s;

endmodule : tdm_slot_counter

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// Receiving end of a time-division-multiplexed link: beat k of each frame is
// routed to channel register k, with a one-cycle valid strobe per channel.
// All outputs are registered; an accepted beat shows up one cycle later.
//
// Ports:
//   clk_i         : rising-edge clock
//   rst_ni        : asynchronous active-low reset, aborts any frame
//   din_i         : beat data (W bits)
//   din_valid_i   : beat present this cycle
//   frame_start_i : current beat is slot 0 (ignored when din_valid_i=0)
//   din_par_i     : even parity over din_i      (TDM_DEMUX_PARITY_EN only)
//   par_err_o     : pulse after a bad-parity beat (TDM_DEMUX_PARITY_EN only)
//   ch_data_o     : packed channel registers, channel k at [k*W +: W]
//   ch_valid_o    : one-cycle strobe, bit k after channel k is written
//   frame_done_o  : one-cycle pulse after the last slot is taken
//   sync_err_o    : one-cycle pulse after an early frame start inside RUN
//   busy_o        : high while the FSM is in RUN
//
// Optional feature macro: TDM_DEMUX_PARITY_EN. When defined, a beat with bad
// parity still advances the slot/state but does not write its channel.
// -----------------------------------------------------------------------------
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N_CH = TDM_N_CH,
   parameter int W    = TDM_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [W-1:0]      din_i,
   input  logic              din_valid_i,
   input  logic              frame_start_i,
`ifdef TDM_DEMUX_PARITY_EN
   input  logic              din_par_i,
   output logic              par_err_o,
`endif
   output logic [N_CH*W-1:0] ch_data_o,
   output logic [N_CH-1:0]   ch_valid_o,
   output logic              frame_done_o,
   output logic              sync_err_o,
   output logic              busy_o
);

   localparam int SLOT_W = slot_w(N_CH);

`ifdef TDM_DEMUX_PARITY_EN
   // Non-zero when {d,p} does not have even parity.
   function automatic logic even_par_bad(input logic [W-1:0] d, input logic p);
      return ^{d, p};
   endfunction
`endif

   tdm_state_t        state_q;
   logic [N_CH*W-1:0] ch_data_q;
   logic [N_CH-1:0]   ch_valid_q;
   logic [N_CH-1:0]   ch_valid_d;
   logic              frame_done_q;
   logic              sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   logic              par_err_q;
`endif

   logic [SLOT_W-1:0] slot_s;
   logic              slot_last_s;
   logic              start_s;      // accepted beat flagged as slot 0
   logic              cont_s;       // accepted continuation beat inside RUN
   logic              resync_s;     // frame start arriving while in RUN
   logic              last_beat_s;  // continuation beat that fills the last slot
   logic              consume_s;    // beat takes a slot (dropped IDLE beats do not)
   logic              par_ok_s;
   logic              wr_en_s;
   logic [SLOT_W-1:0] wr_idx_s;

   // Beat classification, write slot and channel strobe pattern.
   always_comb begin
      start_s     = din_valid_i & frame_start_i;
      cont_s      = din_valid_i & ~frame_start_i & (state_q == RUN);
      resync_s    = start_s & (state_q == RUN);
      last_beat_s = cont_s & slot_last_s;
      consume_s   = start_s | cont_s;
`ifdef TDM_DEMUX_PARITY_EN
      par_ok_s    = ~even_par_bad(din_i, din_par_i);
`else
      par_ok_s    = 1'b1;
`endif
      wr_en_s     = consume_s & par_ok_s;
      // A frame start always lands in slot 0, whatever the counter holds.
      if (start_s) begin
         wr_idx_s = {SLOT_W{1'b0}};
      end else begin
         wr_idx_s = slot_s;
      end
      ch_valid_d = {N_CH{1'b0}};
      for (int k = 0; k < N_CH; k++) begin
         if (wr_en_s && (wr_idx_s == SLOT_W'(k))) begin
            ch_valid_d[k] = 1'b1;
         end else begin
            ch_valid_d[k] = 1'b0;
         end
      end
   end

   tdm_slot_counter #(
      .N_CH   (N_CH),
      .SLOT_W (SLOT_W)
   ) u_slot_counter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .inc_i        (cont_s),
      .clr_to_one_i (start_s),
      .slot_o       (slot_s),
      .last_o       (slot_last_s)
   );

   // Frame FSM together with every registered output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         ch_data_q    <= {(N_CH*W){1'b0}};
         ch_valid_q   <= {N_CH{1'b0}};
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               // Beats without a frame start are silently dropped here.
               if (start_s) begin
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               // An early frame start keeps the FSM in RUN (counter reloads).
               if (last_beat_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase

         for (int k = 0; k < N_CH; k++) begin
            if (ch_valid_d[k]) begin
               ch_data_q[k*W +: W] <= din_i;
            end else begin
               ch_data_q[k*W +: W] <= ch_data_q[k*W +: W];
            end
         end

         ch_valid_q   <= ch_valid_d;
         frame_done_q <= last_beat_s;
         sync_err_q   <= resync_s;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q    <= consume_s & ~par_ok_s;
`endif
      end
   end

   assign ch_data_o    = ch_data_q;
   assign ch_valid_o   = ch_valid_q;
   assign frame_done_o = frame_done_q;
   assign sync_err_o   = sync_err_q;
   // state_q is itself a register, so busy is registered too.
   assign busy_o       = (state_q == RUN);
`ifdef TDM_DEMUX_PARITY_EN
   assign par_err_o    = par_err_q;
`endif

endmodule : tdm_demux

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
// Directed testbench for tdm_demux (N_CH=4, W=8) with hand-computed
// expected values. Parity scenario is built when TDM_DEMUX_PARITY_EN is set.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tdm_demux;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic              clk;
   logic              rst_n;
   logic [W-1:0]      din;
   logic              din_valid;
   logic              frame_start;
   logic              din_par;
   logic              par_err;
   logic [N_CH*W-1:0] ch_data;
   logic [N_CH-1:0]   ch_valid;
   logic              frame_done;
   logic              sync_err;
   logic              busy;

   int n_vec;
   int n_err;

   tdm_demux #(
      .N_CH (N_CH),
      .W    (W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .din_i         (din),
      .din_valid_i   (din_valid),
      .frame_start_i (frame_start),
`ifdef TDM_DEMUX_PARITY_EN
      .din_par_i     (din_par),
      .par_err_o     (par_err),
`endif
      .ch_data_o     (ch_data),
      .ch_valid_o    (ch_valid),
      .frame_done_o  (frame_done),
      .sync_err_o    (sync_err),
      .busy_o        (busy)
   );

`ifndef TDM_DEMUX_PARITY_EN
   assign par_err = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed differs from expected.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check the strobe outputs and busy in one go.
   task automatic chk_strb(input string tag, input logic [N_CH-1:0] vld,
                           input logic fd, input logic se, input logic bsy);
      chk({tag, ".ch_valid"},   64'(ch_valid),   64'(vld));
      chk({tag, ".frame_done"}, 64'(frame_done), 64'(fd));
      chk({tag, ".sync_err"},   64'(sync_err),   64'(se));
      chk({tag, ".busy"},       64'(busy),       64'(bsy));
   endtask

   // Drive one cycle of input, then move to 1ns after the clock edge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic fs, input logic bad);
      din         = d;
      din_valid   = v;
      frame_start = fs;
      din_par     = (^d) ^ bad;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      din         = 8'h00;
      din_valid   = 1'b0;
      frame_start = 1'b0;
      din_par     = 1'b0;

      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.ch_data", 64'(ch_data), 64'h0);
      chk_strb("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("rst.par_err", 64'(par_err), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- unframed beats in IDLE are dropped
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk_strb("unf0", 4'b0000, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b0);
      chk_strb("unf1", 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("unf.ch_data", 64'(ch_data), 64'h0);

      // ---- single frame, back-to-back beats
      step(1'b1, 8'h11, 1'b1, 1'b0);
      chk_strb("f1.b0", 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      chk_strb("f1.b1", 4'b0010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk_strb("f1.b2", 4'b0100, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h44, 1'b0, 1'b0);
      chk_strb("f1.b3", 4'b1000, 1'b1, 1'b0, 1'b0);
      chk("f1.ch_data", 64'(ch_data), 64'h44332211);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk_strb("f1.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

      // ---- same frame shape with idle gaps between beats
      step(1'b1, 8'h81, 1'b1, 1'b0);
      chk_strb("gap.b0", 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'hEE, 1'b1, 1'b0);
      chk_strb("gap.g0", 4'b0000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h82, 1'b0, 1'b0);
      chk_strb("gap.b1", 4'b0010, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'hEE, 1'b0, 1'b0);
      chk_strb("gap.g1", 4'b0000, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'hEE, 1'b0, 1'b0);
      chk_strb("gap.g2", 4'b0000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h83, 1'b0, 1'b0);
      chk_strb("gap.b2", 4'b0100, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'hEE, 1'b0, 1'b0);
      chk_strb("gap.g3", 4'b0000, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h84, 1'b0, 1'b0);
      chk_strb("gap.b3", 4'b1000, 1'b1, 1'b0, 1'b0);
      chk("gap.ch_data", 64'(ch_data), 64'h84838281);

      // ---- early resync: A0,A1 then a new frame B0..B3
      step(1'b1, 8'hA0, 1'b1, 1'b0);
      chk_strb("rs.a0", 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hA1, 1'b0, 1'b0);
      chk_strb("rs.a1", 4'b0010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hB0, 1'b1, 1'b0);
      chk_strb("rs.b0", 4'b0001, 1'b0, 1'b1, 1'b1);
      chk("rs.b0.ch_data", 64'(ch_data), 64'h8483A1B0);
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      chk_strb("rs.b1", 4'b0010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      chk_strb("rs.b2", 4'b0100, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hB3, 1'b0, 1'b0);
      chk_strb("rs.b3", 4'b1000, 1'b1, 1'b0, 1'b0);
      chk("rs.ch_data", 64'(ch_data), 64'hB3B2B1B0);

      // ---- asynchronous reset between beat 2 and beat 3
      step(1'b1, 8'hC0, 1'b1, 1'b0);
      chk_strb("ar.c0", 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hC1, 1'b0, 1'b0);
      chk_strb("ar.c1", 4'b0010, 1'b0, 1'b0, 1'b1);
      din_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar.ch_data", 64'(ch_data), 64'h0);
      chk_strb("ar.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'hC2, 1'b0, 1'b0);
      chk_strb("ar.c2", 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("ar.c2.ch_data", 64'(ch_data), 64'h0);
      step(1'b1, 8'hD0, 1'b1, 1'b0);
      chk_strb("ar.d0", 4'b0001, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'hD1, 1'b0, 1'b0);
      step(1'b1, 8'hD2, 1'b0, 1'b0);
      step(1'b1, 8'hD3, 1'b0, 1'b0);
      chk_strb("ar.d3", 4'b1000, 1'b1, 1'b0, 1'b0);
      chk("ar.ch_data.final", 64'(ch_data), 64'hD3D2D1D0);

`ifdef TDM_DEMUX_PARITY_EN
      // ---- bad parity on the third beat: slot advances, channel 2 kept
      step(1'b1, 8'h01, 1'b1, 1'b0);
      chk_strb("par.b0", 4'b0001, 1'b0, 1'b0, 1'b1);
      chk("par.b0.par_err", 64'(par_err), 64'h0);
      step(1'b1, 8'h02, 1'b0, 1'b0);
      chk_strb("par.b1", 4'b0010, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h03, 1'b0, 1'b1);
      chk_strb("par.b2", 4'b0000, 1'b0, 1'b0, 1'b1);
      chk("par.b2.par_err", 64'(par_err), 64'h1);
      step(1'b1, 8'h04, 1'b0, 1'b0);
      chk_strb("par.b3", 4'b1000, 1'b1, 1'b0, 1'b0);
      chk("par.b3.par_err", 64'(par_err), 64'h0);
      chk("par.ch_data", 64'(ch_data), 64'h04D20201);
`endif

      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk_strb("end", 4'b0000, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_tdm_demux
